// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single register-file write port between two writeback sources:
// requester 0 (ALU result path) and requester 1 (load/memory return path).
// Arbitration is round-robin on contention. A stall input blocks all grants.
// The winning address and data go into a one-cycle write stage, together with
// the select that steers the 5-bit address 2:1 mux and the data mux.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/addr/data, ready     requester 0 (ALU) request and grant
//   req1_valid/addr/data, ready     requester 1 (load) request and grant
//   rf_stall                        write port unavailable this cycle
//   rf_sel                          registered mux select (0=req0, 1=req1)
//   rf_we, rf_waddr, rf_wdata       registered register-file write port
//
// Optional feature
//   RF_WRITE_ZERO_FILTER_EN : a handshake to address 0 is accepted and
//   loaded into the write stage, but rf_we is not raised for it. Register $0
//   is therefore never written. When the macro is undefined, address 0 is
//   written like any other address.
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rf_stall,
  output logic              rf_sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  // last_grant_r = 1 after reset, so requester 0 wins the first contention.
  logic              last_grant_r;
  logic              grant0_s;
  logic              grant1_s;
  logic              hs_s;
  logic              hs_sel_s;
  logic [ADDR_W-1:0] hs_addr_s;
  logic [DATA_W-1:0] hs_data_s;
  logic              we_next_s;

  logic              rf_sel_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;

  // Round-robin grant decision from the current valids, stall and last grant.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rf_stall) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      // On contention, grant the requester that did not win last time.
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  // A grant is only given to a valid requester, so a grant is a handshake.
  // Select the winning requester's fields for the write stage.
  always_comb begin
    hs_s      = grant0_s | grant1_s;
    hs_sel_s  = 1'b0;
    hs_addr_s = {ADDR_W{1'b0}};
    hs_data_s = {DATA_W{1'b0}};
    if (grant1_s) begin
      hs_sel_s  = 1'b1;
      hs_addr_s = req1_addr;
      hs_data_s = req1_data;
    end else begin
      hs_sel_s  = 1'b0;
      hs_addr_s = req0_addr;
      hs_data_s = req0_data;
    end
  end

  // Write enable for the next cycle, optionally suppressed for register $0.
  always_comb begin
    we_next_s = 1'b0;
`ifdef RF_WRITE_ZERO_FILTER_EN
    if (hs_s && (hs_addr_s != {ADDR_W{1'b0}})) begin
      we_next_s = 1'b1;
    end else begin
      we_next_s = 1'b0;
    end
`else
    if (hs_s) begin
      we_next_s = 1'b1;
    end else begin
      we_next_s = 1'b0;
    end
`endif
  end

  // Last-grant state: changes only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (hs_s) begin
      last_grant_r <= hs_sel_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Write stage: loads on a handshake, otherwise holds fields and drops rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_sel_r   <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else if (hs_s) begin
      rf_we_r    <= we_next_s;
      rf_sel_r   <= hs_sel_s;
      rf_waddr_r <= hs_addr_s;
      rf_wdata_r <= hs_data_s;
    end else begin
      rf_we_r    <= 1'b0;
      rf_sel_r   <= rf_sel_r;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rf_we      = rf_we_r;
  assign rf_sel     = rf_sel_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for rf_write_arbiter.
// A table of per-cycle input vectors with the expected ready outputs drives
// the main sequence. Every cycle, the expected write-stage contents for the
// next edge are pushed to a scoreboard queue. They are popped and compared
// after that edge. Hand-written sequences cover reset at power-up, a
// mid-operation asynchronous reset and contention straight out of reset.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rf_stall;
  logic              rf_sel;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  rf_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_stall   (rf_stall),
    .rf_sel     (rf_sel),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              v0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic              stall;
    logic              e0;
    logic              e1;
  } vec_t;

  typedef struct packed {
    logic              we;
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];
  wr_t  sb_q [$];

  int checks;
  int errors;

  // Bench-side write-stage fields.
  logic              hold_sel;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_we(input logic [ADDR_W-1:0] a);
`ifdef RF_WRITE_ZERO_FILTER_EN
    logic [ADDR_W-1:0] zero_a;
    zero_a = {ADDR_W{1'b0}};
    return (a != zero_a);
`else
    a = a;
    return 1'b1;
`endif
  endfunction

  // Drives one cycle's inputs and checks the ready outputs.
  // Pushes the expected write stage, waits for the edge, then pops and compares.
  // This task is entered shortly after a negedge and returns at the next negedge.
  task automatic run_cycle(input vec_t v, input string tag);
    wr_t e;
    wr_t got;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    rf_stall   = v.stall;
    #1;
    check({tag, " req0_ready"}, 32'(req0_ready), 32'(v.e0));
    check({tag, " req1_ready"}, 32'(req1_ready), 32'(v.e1));
    e.we = 1'b0;
    if (v.e0) begin
      hold_sel = 1'b0; hold_addr = v.a0; hold_data = v.d0; e.we = exp_we(v.a0);
    end else if (v.e1) begin
      hold_sel = 1'b1; hold_addr = v.a1; hold_data = v.d1; e.we = exp_we(v.a1);
    end
    e.sel = hold_sel; e.addr = hold_addr; e.data = hold_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected one entry", tag);
    end else begin
      got = sb_q.pop_front();
      check({tag, " rf_we"},    32'(rf_we),    32'(got.we));
      check({tag, " rf_sel"},   32'(rf_sel),   32'(got.sel));
      check({tag, " rf_waddr"}, 32'(rf_waddr), 32'(got.addr));
      check({tag, " rf_wdata"}, 32'(rf_wdata), got.data);
    end
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " rf_we"},    32'(rf_we),    32'd0);
    check({tag, " rf_sel"},   32'(rf_sel),   32'd0);
    check({tag, " rf_waddr"}, 32'(rf_waddr), 32'd0);
    check({tag, " rf_wdata"}, 32'(rf_wdata), 32'd0);
  endtask

  initial begin
    vec_t cv;
    checks = 0;
    errors = 0;
    hold_sel = 1'b0; hold_addr = 5'd0; hold_data = 32'd0;

    //                v0    a0     d0             v1    a1     d1          stall e0    e1
    vecs[0]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 1'b0}; // idle
    vecs[1]  = '{1'b1, 5'd8,  32'hDEADBEEF,   1'b0, 5'd0,  32'h0,     1'b0, 1'b1, 1'b0}; // single req0
    vecs[2]  = '{1'b1, 5'd1,  32'h11,         1'b1, 5'd2,  32'h22,    1'b0, 1'b0, 1'b1}; // lg=0 -> req1
    vecs[3]  = '{1'b1, 5'd1,  32'h11,         1'b1, 5'd4,  32'h44,    1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'd5,  32'h55,         1'b1, 5'd4,  32'h44,    1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 5'd5,  32'h55,         1'b1, 5'd6,  32'h66,    1'b0, 1'b1, 1'b0}; // lg=0 after
    vecs[6]  = '{1'b1, 5'd7,  32'h77,         1'b1, 5'd6,  32'h66,    1'b1, 1'b0, 1'b0}; // stall x3
    vecs[7]  = '{1'b1, 5'd7,  32'h77,         1'b1, 5'd6,  32'h66,    1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd7,  32'h77,         1'b1, 5'd6,  32'h66,    1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd7,  32'h77,         1'b1, 5'd6,  32'h66,    1'b0, 1'b0, 1'b1}; // pre-stall order
    vecs[10] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd9,  32'h99,    1'b0, 1'b0, 1'b1}; // single req1 again
    vecs[11] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd10, 32'hAA,    1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 5'd3,  32'hA,          1'b1, 5'd3,  32'hB,     1'b0, 1'b1, 1'b0}; // same addr: A
    vecs[13] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd3,  32'hB,     1'b0, 1'b0, 1'b1}; // then B
    vecs[14] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd0,  32'h1234,  1'b0, 1'b0, 1'b1}; // addr 0
    vecs[15] = '{1'b1, 5'd12, 32'hC0,         1'b1, 5'd13, 32'hD0,    1'b0, 1'b1, 1'b0}; // req0 wins
    vecs[16] = '{1'b1, 5'd14, 32'hE0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 1'b0}; // stalled single
    vecs[17] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,     1'b0, 1'b0, 1'b0}; // idle

    // Power-up reset.
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    rf_stall = 1'b0;
    @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven main sequence.
    for (int i = 0; i < NVEC; i++) begin
      run_cycle(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-operation reset: req1 to addr 31, with reset pulled between edges.
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 32'hCAFEF00D;
    rf_stall = 1'b0;
    #1;
    check("midrst req1_ready", 32'(req1_ready), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst async");
    @(posedge clk);
    #1;
    check_zero_outputs("midrst no write");
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    sb_q.delete();
    hold_sel = 1'b0; hold_addr = 5'd0; hold_data = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention straight out of reset: grants 0,1,0,1 with rf_we held high.
    for (int k = 0; k < 4; k++) begin
      cv = '{1'b1, ADDR_W'(k + 16), 32'(32'h100 + k), 1'b1, ADDR_W'(k + 20), 32'(32'h200 + k),
             1'b0, (k % 2 == 0) ? 1'b1 : 1'b0, (k % 2 == 1) ? 1'b1 : 1'b0};
      run_cycle(cv, $sformatf("post-reset contention %0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
